mc_core_sequencer: RTL and testbench
====================================

Name: mc_core_sequencer

Overview:
Multi-cycle successor to the single-cycle NPC top-level control. Owns PC, instruction register and load-data register, and sequences fetch / execute / memory / writeback over valid-ready buses instead of combinational instruction and memory ports. The existing decoder, ALU, regfile and CSR logic stay combinational around it; this block gates their write enables with a one-cycle commit pulse. Adds bus wait-state tolerance, bus-error and timeout faults, and a clean halt.

Parameters:
DATA_WIDTH, 32, data/instruction bus width
ADDR_WIDTH, 32, address width of PC and both buses
RESET_PC, 32'h8000_0000, PC value after reset
TIMEOUT, 255, max cycles waiting on any single handshake before a fault; 0 disables

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_addr  out  ADDR_WIDTH  fetch address (= pc)
ifu_rsp_valid  in  1  fetch data valid
ifu_rsp_data  in  DATA_WIDTH  fetched instruction
ifu_rsp_err  in  1  fetch bus error, qualified by ifu_rsp_valid
inst  out  DATA_WIDTH  instruction register to decoder
pc  out  ADDR_WIDTH  current PC
dec_load  in  1  decoded instruction is a load
dec_store  in  1  decoded instruction is a store
dec_halt  in  1  decoded ebreak
next_pc  in  ADDR_WIDTH  PC computed by datapath
mem_addr  in  ADDR_WIDTH  load/store address from ALU
mem_wdata  in  DATA_WIDTH  store data
mem_wmask  in  DATA_WIDTH/8  store byte mask
lsu_req_valid  out  1  data request valid
lsu_req_ready  in  1  data request accepted
lsu_we  out  1  1 = store
lsu_addr  out  ADDR_WIDTH  registered data address
lsu_wdata  out  DATA_WIDTH  registered store data
lsu_wmask  out  DATA_WIDTH/8  registered store mask
lsu_rsp_valid  in  1  load data / store ack valid
lsu_rsp_data  in  DATA_WIDTH  load data
lsu_rsp_err  in  1  data bus error, qualified by lsu_rsp_valid
load_data  out  DATA_WIDTH  latched load data for writeback mux
commit  out  1  one-cycle pulse: regfile/CSR write enable qualifier, pc update
halted  out  1  core stopped
fault  out  2  0 none, 1 fetch error, 2 data error, 3 timeout

Behaviour:
- Reset (async): state=RESET, pc=RESET_PC, inst=0, load_data=0, all valids/commit/halted=0, fault=0, lsu_* regs=0, timeout counter=0.
- States: RESET -> IF_REQ -> IF_WAIT -> EXEC -> (LS_REQ -> LS_WAIT) -> WB -> IF_REQ; HALT terminal.
- RESET: one cycle, then IF_REQ (release from reset is never mid-request).
- IF_REQ: ifu_req_valid=1, ifu_addr=pc held stable until ifu_req_ready. Ready -> IF_WAIT.
- IF_WAIT: on ifu_rsp_valid: err -> HALT, fault=1; else inst<=ifu_rsp_data, -> EXEC. A response in the same cycle as the accept is not legal; ignored in IF_REQ.
- EXEC: one cycle, decoder settles. dec_halt -> WB with commit, then HALT, fault=0. dec_load|dec_store -> latch mem_addr/wdata/wmask into lsu_*, lsu_we=dec_store, -> LS_REQ. Both set: load wins, lsu_we=0. Else -> WB.
- LS_REQ: lsu_req_valid=1, lsu_* stable until lsu_req_ready -> LS_WAIT.
- LS_WAIT: on lsu_rsp_valid: err -> HALT, fault=2, no commit; else load_data<=lsu_rsp_data on loads (unchanged on stores), -> WB.
- WB: commit=1 exactly one cycle, pc<=next_pc (pc+4 for halt). -> IF_REQ (or HALT after dec_halt).
- HALT: halted=1, no requests, pc frozen; only rst exits.
- Timeout: counter clears on entering IF_REQ/IF_WAIT/LS_REQ/LS_WAIT, increments each waiting cycle; reaching TIMEOUT -> HALT, fault=3, no commit. TIMEOUT=0 never fires.
- Minimum instruction latency: 4 cycles non-memory (IF_REQ, IF_WAIT, EXEC, WB) with zero-wait bus; 6 with memory.
- pc/ifu_addr bits [1:0] are passed through; alignment checks are the datapath's job.
- Reset asserted mid-transaction drops valids immediately; bus slaves must tolerate an abandoned transaction.

Test Plan:
- Reset release, zero-wait fetch of 32'h00000013, next_pc=RESET_PC+4 -> ifu_addr=32'h8000_0000, commit high in cycle 4 only, pc=32'h8000_0004 afterwards.
- ifu_req_ready held low 5 cycles -> ifu_req_valid and ifu_addr stable all 5 cycles, no commit, fetch completes normally.
- Load, mem_addr=32'h8000_0100, rsp data 32'hDEADBEEF after 3 wait cycles -> lsu_we=0, lsu_addr=32'h8000_0100, load_data=32'hDEADBEEF on commit cycle, 9-cycle instruction.
- Store, wmask=4'b0011, wdata=32'h1234_5678 -> lsu_we=1, lsu_wmask/wdata stable until ready, load_data unchanged, one commit.
- lsu_rsp_err=1 -> HALT, fault=2, halted=1, no commit, pc unchanged; TIMEOUT=8 with ifu_rsp_valid never -> fault=3 after 8 waiting cycles.
- dec_halt -> one commit, halted=1, fault=0, no further ifu_req_valid; rst pulse mid-IF_WAIT -> all outputs to reset values asynchronously, refetch from 32'h8000_0000.

Source files
------------

// File: rtl/mc_core_sequencer_if.sv
// Instruction-fetch and load/store valid-ready buses of the multi-cycle core.
//   master : sequencer side (drives requests, receives responses)
//   slave  : memory/bus side (accepts requests, drives responses)
// Fetch  : ifu_req_valid/ready, ifu_addr, ifu_rsp_valid/data/err
// Data   : lsu_req_valid/ready, lsu_we/addr/wdata/wmask, lsu_rsp_valid/data/err
interface mc_core_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    ifu_rsp_valid;
  logic [DATA_WIDTH-1:0]   ifu_rsp_data;
  logic                    ifu_rsp_err;

  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic                    lsu_we;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    lsu_rsp_valid;
  logic [DATA_WIDTH-1:0]   lsu_rsp_data;
  logic                    lsu_rsp_err;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err
  );
endinterface

// File: rtl/mc_core_sequencer.sv
// Multi-cycle core sequencer: owns PC, instruction register and load-data
// register; steps fetch / execute / memory / writeback over valid-ready buses
// and qualifies datapath writes with a one-cycle commit pulse.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             fetch + load/store buses (master side)
//   inst, pc        instruction register and PC to the datapath
//   dec_load/store/halt, next_pc, mem_addr/wdata/wmask  decoder/ALU results
//   load_data       latched load data for the writeback mux
//   commit          one-cycle write-enable qualifier / PC update
//   halted, fault   stop flag; 0 none, 1 fetch err, 2 data err, 3 timeout
module mc_core_sequencer #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  mc_core_sequencer_if.master     bus,
  output logic [DATA_WIDTH-1:0]   inst,
  output logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    dec_load,
  input  logic                    dec_store,
  input  logic                    dec_halt,
  input  logic [ADDR_WIDTH-1:0]   next_pc,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    commit,
  output logic                    halted,
  output logic [1:0]              fault
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET, S_IF_REQ, S_IF_WAIT, S_EXEC, S_LS_REQ, S_LS_WAIT, S_WB, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE, FLT_FETCH, FLT_DATA, FLT_TIMEOUT
  } fault_e;

  state_e        state;
  fault_e        fault_q;
  logic          halt_pend;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign bus.ifu_addr = pc;
  assign fault        = fault_q;

  // The counter holds the number of cycles already spent waiting in the
  // current handshake state; firing on TMO_LAST gives exactly TIMEOUT cycles.
  always_comb begin
    tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_RESET;
      pc                <= RESET_PC;
      inst              <= '0;
      load_data         <= '0;
      commit            <= 1'b0;
      halted            <= 1'b0;
      fault_q           <= FLT_NONE;
      halt_pend         <= 1'b0;
      tmo_cnt           <= '0;
      bus.ifu_req_valid <= 1'b0;
      bus.lsu_req_valid <= 1'b0;
      bus.lsu_we        <= 1'b0;
      bus.lsu_addr      <= '0;
      bus.lsu_wdata     <= '0;
      bus.lsu_wmask     <= '0;
    end else begin
      commit <= 1'b0;
      unique case (state)
        S_RESET: begin
          bus.ifu_req_valid <= 1'b1;
          tmo_cnt           <= '0;
          state             <= S_IF_REQ;
        end
        S_IF_REQ: begin
          if (bus.ifu_req_ready) begin
            bus.ifu_req_valid <= 1'b0;
            tmo_cnt           <= '0;
            state             <= S_IF_WAIT;
          end else if (tmo_hit) begin
            bus.ifu_req_valid <= 1'b0;
            fault_q           <= FLT_TIMEOUT;
            halted            <= 1'b1;
            state             <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_IF_WAIT: begin
          if (bus.ifu_rsp_valid) begin
            if (bus.ifu_rsp_err) begin
              fault_q <= FLT_FETCH;
              halted  <= 1'b1;
              state   <= S_HALT;
            end else begin
              inst  <= bus.ifu_rsp_data;
              state <= S_EXEC;
            end
          end else if (tmo_hit) begin
            fault_q <= FLT_TIMEOUT;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (dec_halt) begin
            halt_pend <= 1'b1;
            commit    <= 1'b1;
            state     <= S_WB;
          end else if (dec_load || dec_store) begin
            // A load+store decode is treated as a load.
            bus.lsu_we        <= dec_store && !dec_load;
            bus.lsu_addr      <= mem_addr;
            bus.lsu_wdata     <= mem_wdata;
            bus.lsu_wmask     <= mem_wmask;
            bus.lsu_req_valid <= 1'b1;
            tmo_cnt           <= '0;
            state             <= S_LS_REQ;
          end else begin
            commit <= 1'b1;
            state  <= S_WB;
          end
        end
        S_LS_REQ: begin
          if (bus.lsu_req_ready) begin
            bus.lsu_req_valid <= 1'b0;
            tmo_cnt           <= '0;
            state             <= S_LS_WAIT;
          end else if (tmo_hit) begin
            bus.lsu_req_valid <= 1'b0;
            fault_q           <= FLT_TIMEOUT;
            halted            <= 1'b1;
            state             <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_LS_WAIT: begin
          if (bus.lsu_rsp_valid) begin
            if (bus.lsu_rsp_err) begin
              fault_q <= FLT_DATA;
              halted  <= 1'b1;
              state   <= S_HALT;
            end else begin
              if (!bus.lsu_we) load_data <= bus.lsu_rsp_data;
              commit <= 1'b1;
              state  <= S_WB;
            end
          end else if (tmo_hit) begin
            fault_q <= FLT_TIMEOUT;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_WB: begin
          if (halt_pend) begin
            pc     <= pc + ADDR_WIDTH'(4);
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc                <= next_pc;
            bus.ifu_req_valid <= 1'b1;
            tmo_cnt           <= '0;
            state             <= S_IF_REQ;
          end
        end
        S_HALT: begin
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_sequencer.sv
module tb_mc_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst, pc, next_pc, mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_wmask;
  logic        dec_load, dec_store, dec_halt, commit, halted;
  logic [1:0]  fault;

  always #5 clk = ~clk;

  mc_core_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mc_core_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h8000_0000), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .inst(inst), .pc(pc),
    .dec_load(dec_load), .dec_store(dec_store), .dec_halt(dec_halt),
    .next_pc(next_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .load_data(load_data), .commit(commit),
    .halted(halted), .fault(fault)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ld;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_pc, m_ld;

  // Per-instruction stimulus configuration
  logic [31:0] c_word, c_npc, c_maddr, c_wdata, c_rdata;
  logic [3:0]  c_wmask;
  logic        c_load, c_store, c_halt, c_ferr, c_lerr, c_fnever;
  int          c_if_stall, c_ls_stall, c_ls_wait;

  // Observations of the last instruction
  int          o_cycles, o_commits, o_commit_cyc, o_wait_cyc;
  logic        o_if_stable, o_ls_stable, o_halted_seen, o_expired;
  logic [31:0] o_first_addr, o_lsu_addr, o_lsu_wdata;
  logic [3:0]  o_lsu_wmask;
  logic        o_lsu_we;

  // Scoreboard: each commit pops the expected PC / load_data pair
  always @(negedge clk) begin
    if (!rst && commit === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected got pc=%h want no commit", pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pc !== e.pc || load_data !== e.ld) begin
          bad++;
          $display("FAIL commit_state got pc=%h ld=%h want pc=%h ld=%h",
                   pc, load_data, e.pc, e.ld);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;   bus.ifu_rsp_err   = 1'b0;
    bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rsp_data  = '0;   bus.lsu_rsp_err   = 1'b0;
    dec_load = 1'b0; dec_store = 1'b0; dec_halt = 1'b0;
    next_pc = '0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
  endtask

  task automatic cfg_default();
    c_word = 32'h0000_0013; c_npc = m_pc + 32'd4;
    c_maddr = '0; c_wdata = '0; c_rdata = '0; c_wmask = '0;
    c_load = 1'b0; c_store = 1'b0; c_halt = 1'b0;
    c_ferr = 1'b0; c_lerr = 1'b0; c_fnever = 1'b0;
    c_if_stall = 0; c_ls_stall = 0; c_ls_wait = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC;
    m_ld = '0;
  endtask

  // Acts as the bus slaves and decoder for one instruction. Starts in the
  // IF_REQ cycle, returns at the negedge of the WB cycle (or of the failing
  // response / once halted is seen).
  task automatic run_instr(input int budget);
    int ph = 0;
    int cnt = 0;
    o_cycles = 0; o_commits = 0; o_commit_cyc = 0; o_wait_cyc = 0;
    o_if_stable = 1'b1; o_ls_stable = 1'b1; o_halted_seen = 1'b0;
    o_expired = 1'b0; o_first_addr = 'x;
    while (ph != 6) begin
      @(negedge clk);
      if (o_cycles >= budget) begin o_expired = 1'b1; break; end
      o_cycles++;
      if (halted === 1'b1) begin o_halted_seen = 1'b1; break; end
      if (commit === 1'b1) begin o_commits++; o_commit_cyc = o_cycles; end
      case (ph)
        0: begin
          bus.lsu_rsp_valid = 1'b0;
          if (cnt == 0) o_first_addr = bus.ifu_addr;
          if (bus.ifu_req_valid !== 1'b1 || bus.ifu_addr !== o_first_addr)
            o_if_stable = 1'b0;
          if (cnt < c_if_stall) begin bus.ifu_req_ready = 1'b0; cnt++; end
          else begin bus.ifu_req_ready = 1'b1; ph = 1; cnt = 0; end
        end
        1: begin
          bus.ifu_req_ready = 1'b0;
          if (c_fnever) begin
            bus.ifu_rsp_valid = 1'b0;
            o_wait_cyc++;
          end else begin
            bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_data = c_word;
            bus.ifu_rsp_err = c_ferr;
            ph = c_ferr ? 6 : 2;
          end
        end
        2: begin
          bus.ifu_rsp_valid = 1'b0; bus.ifu_rsp_err = 1'b0;
          dec_load = c_load; dec_store = c_store; dec_halt = c_halt;
          next_pc = c_npc; mem_addr = c_maddr; mem_wdata = c_wdata;
          mem_wmask = c_wmask;
          ph = (!c_halt && (c_load || c_store)) ? 3 : 5;
        end
        3: begin
          if (cnt == 0) begin
            o_lsu_we = bus.lsu_we; o_lsu_addr = bus.lsu_addr;
            o_lsu_wdata = bus.lsu_wdata; o_lsu_wmask = bus.lsu_wmask;
          end
          if (bus.lsu_req_valid !== 1'b1 || bus.lsu_we !== o_lsu_we ||
              bus.lsu_addr !== o_lsu_addr || bus.lsu_wdata !== o_lsu_wdata ||
              bus.lsu_wmask !== o_lsu_wmask)
            o_ls_stable = 1'b0;
          if (cnt < c_ls_stall) begin bus.lsu_req_ready = 1'b0; cnt++; end
          else begin bus.lsu_req_ready = 1'b1; ph = 4; cnt = 0; end
        end
        4: begin
          bus.lsu_req_ready = 1'b0;
          if (cnt < c_ls_wait) begin bus.lsu_rsp_valid = 1'b0; cnt++; end
          else begin
            bus.lsu_rsp_valid = 1'b1; bus.lsu_rsp_data = c_rdata;
            bus.lsu_rsp_err = c_lerr;
            ph = c_lerr ? 6 : 5;
          end
        end
        default: begin
          bus.lsu_rsp_valid = 1'b0;
          ph = 6;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++; if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, RST_PC); end
    total++; if (inst !== 32'h0 || load_data !== 32'h0) begin bad++; $display("FAIL reset_regs got inst=%h ld=%h want 0 0", inst, load_data); end
    total++; if ({bus.ifu_req_valid, bus.lsu_req_valid, commit, halted, fault} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {bus.ifu_req_valid, bus.lsu_req_valid, commit, halted, fault});
    end
    total++; if ({bus.lsu_we, bus.lsu_addr, bus.lsu_wdata, bus.lsu_wmask} !== 69'h0) begin bad++; $display("FAIL reset_lsu got addr=%h want 0", bus.lsu_addr); end
    rst = 1'b0;
    m_pc = RST_PC;
    m_ld = '0;
    #1;
    total++; if (bus.ifu_req_valid !== 1'b0) begin bad++; $display("FAIL reset_cycle_req got=%b want=0", bus.ifu_req_valid); end
  endtask

  task automatic test_basic();
    cfg_default();
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (o_first_addr !== 32'h8000_0000) begin bad++; $display("FAIL basic_addr got=%h want=80000000", o_first_addr); end
    total++; if (o_cycles != 4 || o_commit_cyc != 4 || o_commits != 1 || o_expired) begin
      bad++; $display("FAIL basic_timing got cyc=%0d commit_at=%0d n=%0d want 4 4 1", o_cycles, o_commit_cyc, o_commits);
    end
    @(posedge clk); #1;
    total++; if (pc !== 32'h8000_0004) begin bad++; $display("FAIL basic_pc got=%h want=80000004", pc); end
    total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL basic_inst got=%h want=00000013", inst); end
  endtask

  task automatic test_fetch_stall();
    logic [31:0] pc0;
    cfg_default();
    pc0 = m_pc;
    c_word = 32'h00a0_0093; c_npc = m_pc + 32'd8; c_if_stall = 5;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (!o_if_stable || o_first_addr !== pc0) begin bad++; $display("FAIL fstall_stable got stable=%b addr=%h want 1 %h", o_if_stable, o_first_addr, pc0); end
    total++; if (o_cycles != 9 || o_commit_cyc != 9 || o_commits != 1) begin
      bad++; $display("FAIL fstall_timing got cyc=%0d commit_at=%0d n=%0d want 9 9 1", o_cycles, o_commit_cyc, o_commits);
    end
  endtask

  task automatic test_load();
    cfg_default();
    c_word = 32'h0000_2083; c_load = 1'b1; c_maddr = 32'h8000_0100;
    c_rdata = 32'hDEAD_BEEF; c_ls_wait = 3;
    m_ld = 32'hDEAD_BEEF;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (o_lsu_we !== 1'b0 || o_lsu_addr !== 32'h8000_0100 || !o_ls_stable) begin
      bad++; $display("FAIL load_req got we=%b addr=%h want 0 80000100", o_lsu_we, o_lsu_addr);
    end
    total++; if (o_cycles != 9 || o_commit_cyc != 9 || o_commits != 1) begin
      bad++; $display("FAIL load_timing got cyc=%0d commit_at=%0d want 9 9", o_cycles, o_commit_cyc);
    end
    @(posedge clk); #1;
    total++; if (load_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", load_data); end
  endtask

  task automatic test_store();
    cfg_default();
    c_word = 32'h0011_2023; c_store = 1'b1; c_maddr = 32'h8000_0200;
    c_wdata = 32'h1234_5678; c_wmask = 4'b0011; c_rdata = 32'hBAD0_BAD0;
    c_ls_stall = 3; c_ls_wait = 1;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (o_lsu_we !== 1'b1 || o_lsu_wmask !== 4'b0011 || o_lsu_wdata !== 32'h1234_5678 || o_lsu_addr !== 32'h8000_0200) begin
      bad++; $display("FAIL store_req got we=%b mask=%b wdata=%h addr=%h want 1 0011 12345678 80000200", o_lsu_we, o_lsu_wmask, o_lsu_wdata, o_lsu_addr);
    end
    total++; if (!o_ls_stable || o_commits != 1 || o_cycles != 10) begin
      bad++; $display("FAIL store_hold got stable=%b n=%0d cyc=%0d want 1 1 10", o_ls_stable, o_commits, o_cycles);
    end
    @(posedge clk); #1;
    total++; if (load_data !== m_ld) begin bad++; $display("FAIL store_ld_kept got=%h want=%h", load_data, m_ld); end
  endtask

  task automatic test_load_store_both();
    cfg_default();
    c_load = 1'b1; c_store = 1'b1; c_maddr = 32'h8000_0300;
    c_rdata = 32'h0F0F_0001;
    m_ld = c_rdata;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (o_lsu_we !== 1'b0 || o_cycles != 6) begin bad++; $display("FAIL both_load_wins got we=%b cyc=%0d want 0 6", o_lsu_we, o_cycles); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      int exp_cyc;
      cfg_default();
      c_word = $urandom;
      c_npc  = $urandom;
      c_load = (i % 2 == 1);
      if (c_load) begin
        c_maddr = $urandom; c_rdata = $urandom;
        c_ls_wait = $urandom_range(0, 2);
        m_ld = c_rdata;
        exp_cyc = 6 + c_ls_wait;
      end else begin
        exp_cyc = 4;
      end
      sb.push_back('{m_pc, m_ld});
      run_instr(40);
      m_pc = c_npc;
      total++; if (o_cycles != exp_cyc || o_commits != 1 || o_commit_cyc != exp_cyc) begin
        bad++; $display("FAIL b2b_%0d got cyc=%0d n=%0d want %0d 1", i, o_cycles, o_commits, exp_cyc);
      end
    end
  endtask

  task automatic test_fetch_err();
    do_reset();
    cfg_default();
    c_ferr = 1'b1;
    run_instr(40);
    @(posedge clk); #1;
    idle_inputs();
    total++; if (halted !== 1'b1 || fault !== 2'd1 || pc !== RST_PC || o_commits != 0) begin
      bad++; $display("FAIL fetch_err got halted=%b fault=%0d pc=%h want 1 1 %h", halted, fault, pc, RST_PC);
    end
  endtask

  task automatic test_data_err();
    do_reset();
    cfg_default();
    c_npc = 32'h8000_0040;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    cfg_default();
    c_load = 1'b1; c_maddr = 32'h8000_0100; c_rdata = 32'h5555_AAAA;
    c_lerr = 1'b1; c_ls_wait = 1;
    run_instr(40);
    @(posedge clk); #1;
    idle_inputs();
    total++; if (halted !== 1'b1 || fault !== 2'd2 || o_commits != 0) begin
      bad++; $display("FAIL data_err got halted=%b fault=%0d n=%0d want 1 2 0", halted, fault, o_commits);
    end
    repeat (3) @(negedge clk);
    total++; if (pc !== 32'h8000_0040 || load_data !== 32'h0 || bus.ifu_req_valid !== 1'b0) begin
      bad++; $display("FAIL data_err_frozen got pc=%h ld=%h req=%b want 80000040 0 0", pc, load_data, bus.ifu_req_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_default();
    c_fnever = 1'b1;
    run_instr(40);
    idle_inputs();
    total++; if (!o_halted_seen || o_wait_cyc != 8) begin
      bad++; $display("FAIL timeout_cycles got seen=%b wait=%0d want 1 8", o_halted_seen, o_wait_cyc);
    end
    total++; if (fault !== 2'd3 || o_commits != 0) begin bad++; $display("FAIL timeout_fault got=%0d want=3", fault); end
  endtask

  task automatic test_halt();
    logic req_seen;
    do_reset();
    cfg_default();
    c_halt = 1'b1; c_npc = 32'h1234_5678; c_word = 32'h0010_0073;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    total++; if (o_commits != 1 || o_cycles != 4) begin bad++; $display("FAIL halt_commit got n=%0d cyc=%0d want 1 4", o_commits, o_cycles); end
    @(posedge clk); #1;
    idle_inputs();
    total++; if (halted !== 1'b1 || fault !== 2'd0 || pc !== RST_PC + 32'd4) begin
      bad++; $display("FAIL halt_state got halted=%b fault=%0d pc=%h want 1 0 %h", halted, fault, pc, RST_PC + 32'd4);
    end
    req_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ifu_req_valid !== 1'b0 || pc !== RST_PC + 32'd4) req_seen = 1'b1;
    end
    total++; if (req_seen) begin bad++; $display("FAIL halt_quiet got activity=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_default();
    c_npc = 32'h8000_0010; c_word = 32'h0050_0113;
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    @(negedge clk);
    bus.ifu_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (pc !== RST_PC || inst !== 32'h0 || {bus.ifu_req_valid, commit, halted, fault} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_async got pc=%h inst=%h ctrl=%b want %h 0 0", pc, inst, {bus.ifu_req_valid, commit, halted, fault}, RST_PC);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC; m_ld = '0;
    cfg_default();
    sb.push_back('{m_pc, m_ld});
    run_instr(40);
    m_pc = c_npc;
    total++; if (o_first_addr !== 32'h8000_0000 || o_cycles != 4 || o_commits != 1) begin
      bad++; $display("FAIL mid_reset_refetch got addr=%h cyc=%0d want 80000000 4", o_first_addr, o_cycles);
    end
  endtask

  initial begin
    m_pc = RST_PC;
    m_ld = '0;
    test_reset();
    test_basic();
    test_fetch_stall();
    test_load();
    test_store();
    test_load_store_both();
    test_back_to_back();
    test_fetch_err();
    test_data_err();
    test_timeout();
    test_halt();
    test_reset_mid();
    @(negedge clk);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL missing_commits got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1);
  end

endmodule
